stopwatch_data_gen: RTL and testbench

- Upstream data source for the 4-digit 74HC595 dynamic display stage; drives its data/point/seg_en/sign inputs directly.
- Implements a centisecond stopwatch, SS.CC, range 00.00–99.99.
- Controlled by two raw active-low push keys; each key has an on-chip synchroniser and debouncer.
- Blinks the display when the count saturates.

---
 rtl/stopwatch_data_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_stopwatch_data_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_data_gen.sv
// stopwatch_data_gen: centisecond stopwatch (SS.CC, 00.00-99.99) that feeds
// a 4-digit 74HC595 dynamic display and blinks it when the count saturates.
// Ports: sys_clk, sys_rst_n (sync, active-low); key_ss_n / key_clr_n raw
// active-low keys; data (centiseconds), point (DP enables), seg_en, sign,
// running (high in RUN).

module stopwatch_key_db #(
    parameter int DEBOUNCE_MAX = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_pulse
);
    localparam int CW = $clog2(DEBOUNCE_MAX + 1);
    localparam logic [CW-1:0] L_CNT_MAX  = CW'(DEBOUNCE_MAX);
    localparam logic [CW-1:0] L_CNT_FIRE = CW'(DEBOUNCE_MAX - 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_flush;
    logic          r_armed;
    logic          r_pulse;
    logic          w_flushed;

    // The synchroniser holds its reset value for two edges; only after that
    // does r_sync reflect the real key, so arming waits for it.
    assign w_flushed = (r_flush == 2'd2);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_cnt   <= '0;
            r_flush <= 2'd0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta <= i_key_n;
            r_sync <= r_meta;
            if (!w_flushed)
                r_flush <= r_flush + 2'd1;
            // A key held through reset must be released before it can fire.
            if (w_flushed && r_sync)
                r_armed <= 1'b1;
            if (r_sync)
                r_cnt <= '0;
            else if (r_cnt != L_CNT_MAX)
                r_cnt <= r_cnt + CW'(1);
            r_pulse <= r_armed && !r_sync && (r_cnt == L_CNT_FIRE);
        end
    end

    assign o_pulse = r_pulse;
endmodule

module stopwatch_data_gen #(
    parameter int TICK_DIV     = 500000,
    parameter int DEBOUNCE_MAX = 1000000,
    parameter int MAX_COUNT    = 9999,
    parameter int BLINK_TICKS  = 25
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_ss_n,
    input  logic        key_clr_n,
    output logic [13:0] data,
    output logic [3:0]  point,
    output logic        seg_en,
    output logic        sign,
    output logic        running
);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] L_PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] L_BLK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [13:0]   L_MAX      = 14'(MAX_COUNT);
    localparam logic [13:0]   L_MAX_M1   = 14'(MAX_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_running;
    logic [13:0]   r_data;
    logic [13:0]   w_data_nxt;
    logic [PW-1:0] r_pre;
    logic [PW-1:0] w_pre_nxt;
    logic [PW-1:0] w_pre_inc;
    logic [BW-1:0] r_blink;
    logic [BW-1:0] w_blink_nxt;
    logic          r_seg_en;
    logic          w_seg_en_nxt;
    logic          w_ss;
    logic          w_clr;
    logic          w_counting;
    logic          w_tick;

    stopwatch_key_db #(
        .DEBOUNCE_MAX(DEBOUNCE_MAX)
    ) u_key_ss (
        .i_clk  (sys_clk),
        .i_rst_n(sys_rst_n),
        .i_key_n(key_ss_n),
        .o_pulse(w_ss)
    );

    stopwatch_key_db #(
        .DEBOUNCE_MAX(DEBOUNCE_MAX)
    ) u_key_clr (
        .i_clk  (sys_clk),
        .i_rst_n(sys_rst_n),
        .i_key_n(key_clr_n),
        .o_pulse(w_clr)
    );

    assign w_counting = (r_state == S_RUN) || (r_state == S_DONE);
    assign w_tick     = w_counting && (r_pre == L_PRE_LAST);
    assign w_pre_inc  = (r_pre == L_PRE_LAST) ? '0 : r_pre + PW'(1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
        end
    end

    // Saturation beats start/stop so the count can never park at MAX in PAUSE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_ss)
                        w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (w_tick && (r_data >= L_MAX_M1))
                        w_state_nxt = S_DONE;
                    else if (w_ss)
                        w_state_nxt = S_PAUSE;
                end
                S_PAUSE: begin
                    if (w_ss)
                        w_state_nxt = S_RUN;
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_data_nxt   = r_data;
        w_pre_nxt    = r_pre;
        w_blink_nxt  = r_blink;
        w_seg_en_nxt = r_seg_en;
        if (w_clr) begin
            w_data_nxt   = '0;
            w_pre_nxt    = '0;
            w_blink_nxt  = '0;
            w_seg_en_nxt = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_pre_nxt    = '0;
                    w_blink_nxt  = '0;
                    w_seg_en_nxt = 1'b1;
                end
                S_RUN: begin
                    w_pre_nxt    = w_pre_inc;
                    w_seg_en_nxt = 1'b1;
                    if (w_tick && (r_data < L_MAX))
                        w_data_nxt = r_data + 14'd1;
                end
                S_PAUSE: begin
                    w_pre_nxt = r_pre;
                end
                S_DONE: begin
                    w_pre_nxt = w_pre_inc;
                    if (w_tick) begin
                        if (r_blink == L_BLK_LAST) begin
                            w_blink_nxt  = '0;
                            w_seg_en_nxt = !r_seg_en;
                        end else begin
                            w_blink_nxt = r_blink + BW'(1);
                        end
                    end
                end
                default: begin
                    w_pre_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_data   <= '0;
            r_pre    <= '0;
            r_blink  <= '0;
            r_seg_en <= 1'b1;
        end else begin
            r_data   <= w_data_nxt;
            r_pre    <= w_pre_nxt;
            r_blink  <= w_blink_nxt;
            r_seg_en <= w_seg_en_nxt;
        end
    end

    assign data    = r_data;
    assign point   = 4'b0100;
    assign seg_en  = r_seg_en;
    assign sign    = 1'b0;
    assign running = r_running;
endmodule

// File: tb/tb_stopwatch_data_gen.sv
// tb_stopwatch_data_gen: scoreboard bench for stopwatch_data_gen with a
// cycle-count reference model and randomized key activity.

module tb_stopwatch_data_gen;
    localparam int TD = 4;
    localparam int DM = 3;
    localparam int MC = 20;
    localparam int BT = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_ss_n  = 1'b1;
    logic        key_clr_n = 1'b1;
    logic [13:0] data;
    logic [3:0]  point;
    logic        seg_en;
    logic        sign;
    logic        running;

    stopwatch_data_gen #(
        .TICK_DIV    (TD),
        .DEBOUNCE_MAX(DM),
        .MAX_COUNT   (MC),
        .BLINK_TICKS (BT)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_ss_n (key_ss_n),
        .key_clr_n(key_clr_n),
        .data     (data),
        .point    (point),
        .seg_en   (seg_en),
        .sign     (sign),
        .running  (running)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [13:0] data;
        logic        seg_en;
        logic        running;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: mode, cycles spent counting since clear, and per-key history.
    int   mode;
    int   active;
    int   lrun[2];
    bit   seen[2];
    bit   dly[2][3];
    bit   lvl[2];
    bit   ev[2];
    bit   ss_p;
    bit   clr_p;
    int   t;
    exp_t e_p;
    exp_t e_m;

    function automatic void chk(input string nm, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endfunction

    always @(posedge sys_clk) begin
        lvl[0] = key_ss_n;
        lvl[1] = key_clr_n;
        if (!sys_rst_n) begin
            mode   = M_IDLE;
            active = 0;
            for (int i = 0; i < 2; i++) begin
                lrun[i] = 0;
                seen[i] = 1'b0;
                for (int j = 0; j < 3; j++) dly[i][j] = 1'b0;
            end
        end else begin
            // A press detected at sample edge s acts on the stopwatch at s+3.
            ss_p  = dly[0][2];
            clr_p = dly[1][2];
            if (clr_p) begin
                mode   = M_IDLE;
                active = 0;
            end else begin
                if (mode == M_RUN || mode == M_DONE) active++;
                if (mode == M_RUN && active / TD >= MC) mode = M_DONE;
                else if (ss_p) begin
                    if (mode == M_IDLE || mode == M_PAUSE) mode = M_RUN;
                    else if (mode == M_RUN) mode = M_PAUSE;
                end
            end
            for (int i = 0; i < 2; i++) begin
                ev[i] = 1'b0;
                if (lvl[i]) begin
                    lrun[i] = 0;
                    seen[i] = 1'b1;
                end else begin
                    lrun[i]++;
                    if (lrun[i] == DM && seen[i]) ev[i] = 1'b1;
                end
                dly[i][2] = dly[i][1];
                dly[i][1] = dly[i][0];
                dly[i][0] = ev[i];
            end
        end
        t = active / TD;
        e_p.data    = 14'((t > MC) ? MC : t);
        e_p.running = (mode == M_RUN);
        e_p.seg_en  = (mode != M_DONE) || ((((t - MC) / BT) % 2) == 0);
        q.push_back(e_p);
    end

    always @(negedge sys_clk) begin
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
            e_m = q.pop_front();
            chk("data", int'(data), int'(e_m.data));
            chk("seg_en", int'(seg_en), int'(e_m.seg_en));
            chk("running", int'(running), int'(e_m.running));
            chk("point", int'(point), 4);
            chk("sign", int'(sign), 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic press(input bit ss, input bit clr, input int len);
        if (ss) key_ss_n = 1'b0;
        if (clr) key_clr_n = 1'b0;
        cyc(len);
        key_ss_n  = 1'b1;
        key_clr_n = 1'b1;
    endtask

    task automatic wait_data(input int v, input int budget);
        int c = 0;
        while (int'(data) != v && c < budget) begin
            cyc(1);
            c++;
        end
        n_chk++;
        if (int'(data) != v) begin
            n_fail++;
            $display("FAIL wait_data: data=%0d never reached %0d", data, v);
        end
    endtask

    task automatic wait_seg_off(input int budget);
        int c = 0;
        while (seg_en !== 1'b0 && c < budget) begin
            cyc(1);
            c++;
        end
        n_chk++;
        if (seg_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_seg_off: seg_en=%0b never reached 0", seg_en);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        cyc(3);
        sys_rst_n = 1'b1;
        cyc(50);

        press(1'b1, 1'b0, 10);
        cyc(30);
        press(1'b0, 1'b1, 10);
        cyc(10);

        press(1'b1, 1'b0, 2);
        cyc(10);
        press(1'b1, 1'b0, 2);
        cyc(1);
        press(1'b1, 1'b0, 2);
        cyc(10);
        press(1'b1, 1'b0, 10);

        wait_data(7, 100);
        press(1'b1, 1'b0, 10);
        cyc(40);
        press(1'b1, 1'b0, 10);
        cyc(20);

        wait_data(MC, 400);
        repeat (3) begin
            press(1'b1, 1'b0, 6);
            cyc(4);
        end
        cyc(30);
        wait_seg_off(40);
        press(1'b1, 1'b1, 10);
        cyc(10);

        press(1'b1, 1'b0, 10);
        cyc(20);
        press(1'b1, 1'b1, 10);
        cyc(10);

        press(1'b1, 1'b0, 10);
        wait_data(13, 200);
        sys_rst_n = 1'b0;
        cyc(1);
        sys_rst_n = 1'b1;
        cyc(10);

        repeat (400) begin
            int r;
            r = int'($urandom_range(0, 99));
            key_ss_n  = !(r < 30);
            key_clr_n = !(r >= 96);
            if ($urandom_range(0, 199) == 0) sys_rst_n = 1'b0;
            else sys_rst_n = 1'b1;
            cyc(int'($urandom_range(1, 12)));
        end
        sys_rst_n = 1'b1;
        key_ss_n  = 1'b1;
        key_clr_n = 1'b1;
        cyc(20);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
